// File: rtl/swan_pkg.sv
// SWAN key schedule shared types and helpers.
// Mode/state encodings, delta constants, key rotations.
package swan_pkg;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } ks_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FWD,
    S_EMIT
  } ks_state_e;

  localparam logic [15:0] DELTA_16 = 16'h9e37;
  localparam logic [31:0] DELTA_32 = 32'h9e3779b9;
  localparam logic [63:0] DELTA_64 = 64'h9e3779b97f4a7c15;

  localparam int KEY_MAX = 512;
  localparam int KEY_AW  = 9;

  // Rotations act on the low w bits of a KEY_MAX-wide carrier.
  function automatic logic [KEY_MAX-1:0] rotr(
    input logic [KEY_MAX-1:0] k,
    input int                 w,
    input int                 n
  );
    logic [KEY_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_MAX; i++) begin
      if (i < w) r[KEY_AW'(i)] = k[KEY_AW'((i + n) % w)];
    end
    return r;
  endfunction

  function automatic logic [KEY_MAX-1:0] rotl(
    input logic [KEY_MAX-1:0] k,
    input int                 w,
    input int                 n
  );
    logic [KEY_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < KEY_MAX; i++) begin
      if (i < w) r[KEY_AW'(i)] = k[KEY_AW'((i + w - n) % w)];
    end
    return r;
  endfunction

endpackage

// File: rtl/swan_ks_step.sv
// SWAN key schedule step: forward F (inv=0) or inverse G (inv=1).
// Purely combinational.
module swan_ks_step
  import swan_pkg::*;
#(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 256,
  parameter int PD         = 24,
  parameter logic [BLOCK_SIZE/2-1:0] DELTA0 = DELTA_32
) (
  input  logic [KEY_SIZE-1:0]     key,
  input  logic [BLOCK_SIZE/2-1:0] delta,
  input  logic                    inv,
  output logic [KEY_SIZE-1:0]     key_nxt,
  output logic [BLOCK_SIZE/2-1:0] delta_nxt
);

  localparam int S = BLOCK_SIZE / 2;

  logic [KEY_SIZE-1:0] k0f;
  logic [KEY_SIZE-1:0] k0g;
  logic [S-1:0]        df;
  logic [S-1:0]        sf;
  logic [S-1:0]        lg;

  assign k0f = KEY_SIZE'(rotr(KEY_MAX'(key), KEY_SIZE, PD));
  assign df  = delta + DELTA0;
  assign sf  = k0f[S-1:0] + df;

  // Undo the low-word add before undoing the rotation.
  assign lg  = key[S-1:0] - delta;
  assign k0g = KEY_SIZE'(rotl(KEY_MAX'({key[KEY_SIZE-1:S], lg}),
                              KEY_SIZE, PD));

  assign key_nxt   = inv ? k0g : {k0f[KEY_SIZE-1:S], sf};
  assign delta_nxt = inv ? (delta - DELTA0) : df;

endmodule

// File: rtl/swan_key_schedule_seq.sv
// Sequential SWAN round-key generator with valid/ready output.
// Decrypt fast-forwards the schedule, then walks it backwards.
module swan_key_schedule_seq
  import swan_pkg::*;
#(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 256,
  parameter int ROUNDS     = 64,
  parameter int PD         = 24,
  parameter logic [BLOCK_SIZE/2-1:0] DELTA0 = DELTA_32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic [KEY_SIZE-1:0]          key_in,
  output logic [BLOCK_SIZE/2-1:0]      sk,
  output logic                         sk_valid,
  input  logic                         sk_ready,
  output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int S  = BLOCK_SIZE / 2;
  localparam int CW = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] RMAX = CW'(ROUNDS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  ks_state_e           state, state_n;
  ks_mode_e            mode_r, mode_n;
  logic [KEY_SIZE-1:0] key_r, key_n;
  logic [S-1:0]        delta_r, delta_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                valid_n;
  logic                done_n;

  logic [KEY_SIZE-1:0] step_key;
  logic [S-1:0]        step_delta;
  logic                step_inv;
  logic [KEY_SIZE-1:0] nxt_key;
  logic [S-1:0]        nxt_delta;
  logic                last;

  swan_ks_step #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .KEY_SIZE   (KEY_SIZE),
    .PD         (PD),
    .DELTA0     (DELTA0)
  ) u_step (
    .key       (step_key),
    .delta     (step_delta),
    .inv       (step_inv),
    .key_nxt   (nxt_key),
    .delta_nxt (nxt_delta)
  );

  assign last = (mode_r == ENC) ? (cnt == RMAX) : (cnt == ONE);

  always_comb begin
    state_n    = state;
    mode_n     = mode_r;
    key_n      = key_r;
    delta_n    = delta_r;
    cnt_n      = cnt;
    valid_n    = sk_valid;
    done_n     = 1'b0;
    step_key   = key_r;
    step_delta = delta_r;
    step_inv   = (state == S_EMIT) && (mode_r == DEC);
    unique case (state)
      S_IDLE: begin
        step_key   = key_in;
        step_delta = '0;
        if (start) begin
          key_n   = nxt_key;
          delta_n = nxt_delta;
          cnt_n   = ONE;
          mode_n  = ks_mode_e'(mode);
          if (ks_mode_e'(mode) == ENC) begin
            valid_n = 1'b1;
            state_n = S_EMIT;
          end else begin
            state_n = S_FWD;
          end
        end
      end
      S_FWD: begin
        if (cnt < RMAX) begin
          key_n   = nxt_key;
          delta_n = nxt_delta;
          cnt_n   = cnt + ONE;
        end else begin
          valid_n = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (sk_valid && sk_ready) begin
          if (last) begin
            // Clear the key so sk reads zero while idle.
            valid_n = 1'b0;
            done_n  = 1'b1;
            key_n   = '0;
            delta_n = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            key_n   = nxt_key;
            delta_n = nxt_delta;
            cnt_n   = (mode_r == ENC) ? cnt + ONE : cnt - ONE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_r   <= ENC;
      key_r    <= '0;
      delta_r  <= '0;
      cnt      <= '0;
      sk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      mode_r   <= mode_n;
      key_r    <= key_n;
      delta_r  <= delta_n;
      cnt      <= cnt_n;
      sk_valid <= valid_n;
      done     <= done_n;
    end
  end

  assign sk        = key_r[S-1:0];
  assign round_idx = sk_valid ? cnt : '0;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_swan_key_schedule_seq.sv
// Bench for swan_key_schedule_seq: software schedule model,
// per-cycle handshake scoreboard and directed scenarios.
module tb_swan_key_schedule_seq;

  localparam int R = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic         mode = 1'b0;
  logic [255:0] key_in = '0;
  logic         sk_ready = 1'b1;

  logic [31:0]  sk, sk2;
  logic         sk_valid, sk_valid2;
  logic [6:0]   round_idx;
  logic [1:0]   round_idx2;
  logic         busy, busy2;
  logic         done, done2;

  swan_key_schedule_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .key_in    (key_in),
    .sk        (sk),
    .sk_valid  (sk_valid),
    .sk_ready  (sk_ready),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  swan_key_schedule_seq #(.ROUNDS(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .mode      (mode),
    .key_in    (key_in),
    .sk        (sk2),
    .sk_valid  (sk_valid2),
    .sk_ready  (sk_ready),
    .round_idx (round_idx2),
    .busy      (busy2),
    .done      (done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sk;
    int          idx;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] mdl[R];
  logic [31:0] enc_got[R];
  int          n_err = 0;
  int          n_checks = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  bit          bp_rand = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] prev_sk;
  logic [6:0]  prev_idx;
  exp_t        e_cur;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Schedule straight from the rules: rotate, bump delta, add.
  task automatic build(input logic [255:0] k);
    logic [255:0] kk;
    logic [31:0]  d;
    kk = k;
    d  = '0;
    for (int i = 0; i < R; i++) begin
      kk = (kk >> 24) | (kk << 232);
      d  = d + 32'h9e3779b9;
      kk[31:0] = kk[31:0] + d;
      mdl[i] = kk[31:0];
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    sk_ready = bp_rand ? 1'($urandom % 2) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (!sk_valid) begin
        chk("idx_idle", 64'(round_idx), 0);
      end else begin
        if (stall_prev) begin
          chk("hold_sk", 64'(sk), 64'(prev_sk));
          chk("hold_idx", 64'(round_idx), 64'(prev_idx));
        end
        if (sk_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_hs", 1, 0);
          end else begin
            e_cur = exp_q.pop_front();
            chk("sk", 64'(sk), 64'(e_cur.sk));
            chk("idx", 64'(round_idx), 64'(e_cur.idx));
          end
          got_q.push_back(sk);
          hs_cnt++;
        end
      end
      stall_prev = sk_valid && !sk_ready;
      prev_sk    = sk;
      prev_idx   = round_idx;
    end
  end

  task automatic launch(input logic [255:0] k, input bit m);
    int lat;
    build(k);
    exp_q.delete();
    got_q.delete();
    hs_cnt = 0;
    for (int i = 0; i < R; i++) begin
      if (!m) exp_q.push_back('{mdl[i], i + 1});
      else    exp_q.push_back('{mdl[R-1-i], R - i});
    end
    key_in = k;
    mode   = m;
    start  = 1'b1;
    lat    = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start = 1'b0;
      lat = i;
      if (sk_valid) break;
    end
    chk("latency", 64'(lat), m ? 64'(R + 1) : 64'd1);
  endtask

  task automatic wait_done(input bit disturb);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (disturb && i == 5) begin
        start  = 1'b1;
        mode   = ~mode;
        for (int j = 0; j < 8; j++) key_in[j*32 +: 32] = $urandom;
      end
      if (disturb && i == 6) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_pulse", 64'(seen), 1);
    chk("busy_in_done", 64'(busy), 0);
    chk("valid_in_done", 64'(sk_valid), 0);
    chk("sk_idle", 64'(sk), 0);
    chk("exp_left", 64'(exp_q.size()), 0);
    chk("handshakes", 64'(hs_cnt), 64'(R));
  endtask

  initial begin
    logic [255:0] kr;
    int           bad;
    int           dc;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sk", 64'(sk), 0);
    chk("rst_valid", 64'(sk_valid), 0);
    chk("rst_idx", 64'(round_idx), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    build('0);
    chk("model_r1", 64'(mdl[0]), 64'h9e3779b9);
    chk("model_r2", 64'(mdl[1]), 64'h3c6ef410);

    launch('0, 1'b0);
    chk("enc0_r1", 64'(sk), 64'h9e3779b9);
    chk("enc0_i1", 64'(round_idx), 1);
    @(posedge clk);
    #1;
    chk("enc0_r2", 64'(sk), 64'h3c6ef410);
    chk("enc0_i2", 64'(round_idx), 2);
    wait_done(1'b0);
    @(posedge clk);
    #1;

    key_in = '0;
    mode   = 1'b1;
    start2 = 1'b1;
    dc     = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) start2 = 1'b0;
      dc = i;
      if (sk_valid2) break;
    end
    chk("r2_latency", 64'(dc), 3);
    chk("r2_sk_a", 64'(sk2), 64'h3c6ef410);
    chk("r2_idx_a", 64'(round_idx2), 2);
    @(posedge clk);
    #1;
    chk("r2_sk_b", 64'(sk2), 64'h9e3779b9);
    chk("r2_idx_b", 64'(round_idx2), 1);
    @(posedge clk);
    #1;
    chk("r2_done", 64'(done2), 1);
    chk("r2_valid", 64'(sk_valid2), 0);
    chk("r2_busy", 64'(busy2), 0);

    for (int j = 0; j < 8; j++) kr[j*32 +: 32] = $urandom;
    launch(kr, 1'b0);
    wait_done(1'b0);
    for (int i = 0; i < R; i++) enc_got[i] = (i < got_q.size()) ? got_q[i] : 'x;

    bp_rand = 1'b1;
    launch(kr, 1'b1);
    wait_done(1'b1);
    bp_rand = 1'b0;
    bad = 0;
    for (int i = 0; i < R; i++) begin
      if (i >= got_q.size() || got_q[i] !== enc_got[R-1-i]) bad++;
    end
    chk("dec_is_rev_enc", 64'(bad), 0);

    @(posedge clk);
    #1;
    dc = done_cnt;
    launch(kr, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (round_idx == 7'd10) break;
      @(posedge clk);
      #1;
    end
    chk("reached_r10", 64'(round_idx), 10);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_sk", 64'(sk), 0);
    chk("mid_rst_valid", 64'(sk_valid), 0);
    chk("mid_rst_idx", 64'(round_idx), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_done", 64'(done), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("no_done_on_rst", 64'(done_cnt), 64'(dc));

    launch('0, 1'b0);
    chk("post_rst_r1", 64'(sk), 64'h9e3779b9);
    wait_done(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/swan_key_schedule_seq.md
# swan_key_schedule_seq

Sequential, parametrised SWAN round-key generator. It expands a master key into ROUNDS subkeys, one per valid/ready handshake. In encrypt mode it emits the subkeys in forward order. In decrypt mode it first fast-forwards the schedule, then emits the subkeys in reverse order by inverting the step. It sits between the key register file and the round datapath of the SWAN64/128/256 cores.

## Interface
- BLOCK_SIZE, 64: cipher block width. SIDE_SIZE = BLOCK_SIZE/2.
- KEY_SIZE, 256: master key width. Must be greater than SIDE_SIZE + PD.
- ROUNDS, 64: number of subkeys emitted. Must be at least 1.
- PD, 24: key rotation distance in bits.
- DELTA0, 32'h9e3779b9: delta increment, SIDE_SIZE bits wide. Integrators override it for SIDE_SIZE ≠ 32.
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  reset. Synchronous, active-low.
- start  in  1  request a new schedule. Sampled only when busy=0.
- mode  in  1  0 = encrypt (forward order), 1 = decrypt (reverse order).
- key_in  in  KEY_SIZE  master key [0:KEY_SIZE-1], MSB-first. Sampled with start.
- sk  out  SIDE_SIZE  current subkey.
- sk_valid  out  1  sk and round_idx are valid.
- sk_ready  in  1  consumer accepts sk.
- round_idx  out  $clog2(ROUNDS+1)  1-based index of the subkey on sk.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after the last subkey is accepted.

## Operation
- State: key_r (KEY_SIZE bits), delta_r (SIDE_SIZE bits), cnt. The low word is key_r[KEY_SIZE-SIDE_SIZE:KEY_SIZE-1], and sk = low word of key_r.
- Forward step F(K, D):
  - K0 = {K[KEY_SIZE-PD:KEY_SIZE-1], K[0:KEY_SIZE-1-PD]}, i.e. rotate right by PD.
  - D' = D + DELTA0.
  - s = low(K0) + D'.
  - K' = {K0[0:KEY_SIZE-SIDE_SIZE-1], s}.
  - All additions are mod 2^SIDE_SIZE.
- Inverse step G(K', D'):
  - low(K0) = low(K') − D'.
  - K = K0 rotated left by PD.
  - D = D' − DELTA0.
  - All subtractions are mod 2^SIDE_SIZE.
- The initial delta is 0, so subkey r uses delta = r·DELTA0 mod 2^SIDE_SIZE.
- FSM states and transitions:
  - IDLE: all outputs low. On start:
    - key_r, delta_r ← F(key_in, 0). Both modes take this step.
    - cnt ← 1.
    - mode 0: sk_valid ← 1, go to EMIT.
    - mode 1: go to FWD.
  - FWD (decrypt only), each cycle:
    - If cnt < ROUNDS: apply F, cnt++.
    - Else: sk_valid ← 1, go to EMIT.
  - EMIT, on sk_valid && sk_ready:
    - Last subkey (encrypt cnt==ROUNDS, decrypt cnt==1): sk_valid ← 0, done ← 1, go to IDLE.
    - Otherwise encrypt: apply F, cnt++.
    - Otherwise decrypt: apply G, cnt−−.
- round_idx = cnt while sk_valid=1, else 0.
- Mode is latched at start. Changes to mode or key_in after start have no effect.

## Timing
- Reset values: sk=0, sk_valid=0, round_idx=0, busy=0, done=0, state=IDLE. delta_r, key_r and cnt are also cleared.
- Reset asserted mid-schedule: all of the above on the next edge. No done pulse is produced, and the subkey in flight is dropped.
- Encrypt latency: sk_valid rises 1 cycle after the start edge.
- Decrypt latency: sk_valid rises ROUNDS+1 cycles after the start edge.
- Throughput: one subkey per cycle when sk_ready is held high.
- sk, sk_valid and round_idx are registered and held stable while sk_valid && !sk_ready.
- busy is high from the cycle after start is accepted until the cycle done pulses.
- busy is low in the done cycle, so start may be accepted in that same cycle.
- start while busy=1 is ignored.
- ROUNDS=1: encrypt and decrypt both emit only F(key_in, 0)'s subkey. Decrypt spends 1 cycle in FWD.

## Structure
- Shared package swan_pkg holds:
  - mode encoding (ENC=0, DEC=1);
  - per-SIDE_SIZE DELTA0 constants;
  - rotr/rotl key functions;
  - the FSM state enum.
- Sub-module swan_ks_step: combinational. Computes F when inv=0 and G when inv=1, parametrised like the top. Instantiated once. FWD and EMIT share it, with inv = (state==EMIT && mode==DEC).

## Test plan
- Encrypt, key_in=0, sk_ready=1 → sk=0x9e3779b9 (round 1), then 0x3c6ef410 (round 2). delta wraps from 0x13c6ef372 to 0x3c6ef372.
- Decrypt, ROUNDS=2, key_in=0 → sk_valid after 3 cycles. Emits 0x3c6ef410 (round_idx 2), then 0x9e3779b9 (round_idx 1). done follows.
- Random key, ROUNDS=64 → decrypt output is exactly the reversed encrypt output. Compared against a software model.
- Backpressure: sk_ready toggles randomly → no subkey is lost or duplicated, outputs are stable while stalled, and exactly 64 handshakes occur.
- start pulsed while busy, and mode changed mid-run → ignored, and the sequence is unchanged.
- rst_n low during round 10 → all outputs 0 on the next edge. A new start then produces round 1 = 0x9e3779b9 for key 0.
